// File: rtl/fpu_stream_driver.sv
// Initiator for an stb/ack floating-point unit. It buffers operand pairs, issues A then B,
// collects Z, and returns each result on a valid/ready port with a count and a signature.
module fpu_stream_driver #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_a,
  input  logic [WIDTH-1:0]  load_b,
  output logic              load_ready,
  output logic [WIDTH-1:0]  fpu_a,
  output logic              fpu_a_stb,
  input  logic              fpu_a_ack,
  output logic [WIDTH-1:0]  fpu_b,
  output logic              fpu_b_stb,
  input  logic              fpu_b_ack,
  input  logic [WIDTH-1:0]  fpu_z,
  input  logic              fpu_z_stb,
  output logic              fpu_z_ack,
  output logic [WIDTH-1:0]  res_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count,
  output logic [WIDTH-1:0]  signature
);

  localparam int unsigned OCC_W = ADDR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, PUT_RES} state_t;

  state_t             r_state, w_state_n;
  logic [WIDTH-1:0]   r_mem_a [DEPTH];
  logic [WIDTH-1:0]   r_mem_b [DEPTH];
  logic [ADDR_W-1:0]  r_wr, r_rd;
  logic [OCC_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_fpu_a, r_fpu_b, r_res_z, r_sig;
  logic               r_a_stb, r_b_stb, r_z_ack, r_res_valid;
  logic [CNT_W-1:0]   r_txn;

  logic [WIDTH-1:0]   w_fpu_a_n, w_fpu_b_n, w_res_z_n, w_sig_n;
  logic               w_a_stb_n, w_b_stb_n, w_z_ack_n, w_res_valid_n;
  logic [CNT_W-1:0]   w_txn_n;
  logic               w_push, w_pop;

  assign load_ready = (r_count != FULL_OCC);
  assign w_push     = load_valid && load_ready;
  assign busy       = (r_state != IDLE) || (r_count != '0);

  assign fpu_a     = r_fpu_a;
  assign fpu_a_stb = r_a_stb;
  assign fpu_b     = r_fpu_b;
  assign fpu_b_stb = r_b_stb;
  assign fpu_z_ack = r_z_ack;
  assign res_z     = r_res_z;
  assign res_valid = r_res_valid;
  assign txn_count = r_txn;
  assign signature = r_sig;

  // Operand storage; pointers and occupancy alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr] <= load_a;
      r_mem_b[r_wr] <= load_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + ADDR_W'(1);
      if (w_pop)  r_rd <= r_rd + ADDR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_a_stb     <= 1'b0;
      r_b_stb     <= 1'b0;
      r_z_ack     <= 1'b0;
      r_res_z     <= '0;
      r_res_valid <= 1'b0;
      r_txn       <= '0;
      r_sig       <= '0;
    end else begin
      r_state     <= w_state_n;
      r_fpu_a     <= w_fpu_a_n;
      r_fpu_b     <= w_fpu_b_n;
      r_a_stb     <= w_a_stb_n;
      r_b_stb     <= w_b_stb_n;
      r_z_ack     <= w_z_ack_n;
      r_res_z     <= w_res_z_n;
      r_res_valid <= w_res_valid_n;
      r_txn       <= w_txn_n;
      r_sig       <= w_sig_n;
    end
  end

  // One transaction in flight: A, then B (pop), then Z, then hand the result to the host.
  always_comb begin
    w_state_n     = r_state;
    w_fpu_a_n     = r_fpu_a;
    w_fpu_b_n     = r_fpu_b;
    w_a_stb_n     = r_a_stb;
    w_b_stb_n     = r_b_stb;
    w_z_ack_n     = r_z_ack;
    w_res_z_n     = r_res_z;
    w_res_valid_n = r_res_valid;
    w_txn_n       = r_txn;
    w_sig_n       = r_sig;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_fpu_a_n = r_mem_a[r_rd];
          w_a_stb_n = 1'b1;
          w_state_n = SEND_A;
        end
      end
      SEND_A: begin
        if (r_a_stb && fpu_a_ack) begin
          w_a_stb_n = 1'b0;
          w_fpu_b_n = r_mem_b[r_rd];
          w_b_stb_n = 1'b1;
          w_state_n = SEND_B;
        end
      end
      SEND_B: begin
        if (r_b_stb && fpu_b_ack) begin
          w_b_stb_n = 1'b0;
          w_pop     = 1'b1;
          w_z_ack_n = 1'b1;
          w_state_n = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (fpu_z_stb && r_z_ack) begin
          w_res_z_n     = fpu_z;
          w_z_ack_n     = 1'b0;
          w_res_valid_n = 1'b1;
          w_sig_n       = {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ fpu_z;
          w_state_n     = PUT_RES;
        end
      end
      PUT_RES: begin
        if (r_res_valid && res_ready) begin
          w_res_valid_n = 1'b0;
          w_txn_n       = r_txn + CNT_W'(1);
          w_state_n     = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_stream_driver.sv
// Bench for fpu_stream_driver: a behavioural stb/ack unit, a result scoreboard, and a
// second instance with a 2-bit transaction counter sharing the same stimulus.
module tb_fpu_stream_driver;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic [WIDTH-1:0] load_a, load_b;
  logic             fpu_a_ack, fpu_b_ack, fpu_z_stb;
  logic [WIDTH-1:0] fpu_z;
  logic             res_ready;

  logic             load_ready, fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, busy;
  logic [WIDTH-1:0] fpu_a, fpu_b, res_z, signature;
  logic [15:0]      txn_count;

  logic             w2_load_ready, w2_a_stb, w2_b_stb, w2_z_ack, w2_res_valid, w2_busy;
  logic [WIDTH-1:0] w2_a, w2_b, w2_res_z, w2_sig;
  logic [1:0]       w2_txn;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] sig_m = '0;
  logic             z_block = 1'b0;

  always #5 clk = ~clk;

  fpu_stream_driver #(.WIDTH(WIDTH), .DEPTH(4), .ADDR_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_a(load_a), .load_b(load_b),
    .load_ready(load_ready), .fpu_a(fpu_a), .fpu_a_stb(fpu_a_stb), .fpu_a_ack(fpu_a_ack),
    .fpu_b(fpu_b), .fpu_b_stb(fpu_b_stb), .fpu_b_ack(fpu_b_ack), .fpu_z(fpu_z),
    .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack), .res_z(res_z), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .txn_count(txn_count), .signature(signature));

  fpu_stream_driver #(.WIDTH(WIDTH), .DEPTH(4), .ADDR_W(2), .CNT_W(2)) u_dut_w (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_a(load_a), .load_b(load_b),
    .load_ready(w2_load_ready), .fpu_a(w2_a), .fpu_a_stb(w2_a_stb), .fpu_a_ack(fpu_a_ack),
    .fpu_b(w2_b), .fpu_b_stb(w2_b_stb), .fpu_b_ack(fpu_b_ack), .fpu_z(fpu_z),
    .fpu_z_stb(fpu_z_stb), .fpu_z_ack(w2_z_ack), .res_z(w2_res_z), .res_valid(w2_res_valid),
    .res_ready(res_ready), .busy(w2_busy), .txn_count(w2_txn), .signature(w2_sig));

  // Reference adder: exact for the float cases exercised, asymmetric a-b otherwise.
  function automatic logic [WIDTH-1:0] fadd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h7F800000 && b == 32'hFF800000) return 32'hFFC00000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
    return a - b;
  endfunction

  // Behavioural unit: always ready for B, returns Z one cycle after the B transfer.
  initial begin : unit_model
    logic s_rst, s_a, s_b, s_z, pend;
    logic [WIDTH-1:0] av, bv, ua;
    fpu_z_stb = 1'b0;
    fpu_z = '0;
    fpu_b_ack = 1'b1;
    pend = 1'b0;
    ua = '0;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_a = fpu_a_stb && fpu_a_ack;
      s_b = fpu_b_stb && fpu_b_ack;
      s_z = fpu_z_stb && fpu_z_ack;
      av = fpu_a;
      bv = fpu_b;
      #1;
      if (s_rst) begin
        pend = 1'b0;
        fpu_z_stb = 1'b0;
      end else begin
        if (s_a) ua = av;
        if (s_z) fpu_z_stb = 1'b0;
        if (s_b) begin
          fpu_z = fadd_ref(ua, bv);
          pend = 1'b1;
        end
        if (pend && !z_block && !fpu_z_stb) begin
          fpu_z_stb = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every host-side result handshake must match the oldest expected result.
  initial begin : result_monitor
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      if (!rst && res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got=%h expected=none", res_z);
        end else begin
          e = exp_q.pop_front();
          if (res_z !== e) begin
            failures++;
            $display("FAIL result_order got=%h expected=%h", res_z, e);
          end
          sig_m = {sig_m[WIDTH-2:0], sig_m[WIDTH-1]} ^ e;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    sig_m = '0;
  endtask

  task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit done = 1'b0;
    load_a = a;
    load_b = b;
    load_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (load_ready) begin
        exp_q.push_back(fadd_ref(a, b));
        done = 1'b1;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got=load_ready_low expected=accept");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !res_valid && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy expected=idle pending=%0d", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_load_ready got=%b expected=1", load_ready); end
    checks++; if ({fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, busy} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b expected=00000", {fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, busy}); end
    checks++; if ({fpu_a, fpu_b, res_z} !== '0) begin failures++; $display("FAIL rst_data got=%h/%h/%h expected=0", fpu_a, fpu_b, res_z); end
    checks++; if (txn_count !== 16'd0 || signature !== '0) begin failures++; $display("FAIL rst_count_sig got=%0d/%h expected=0/0", txn_count, signature); end
  endtask

  task automatic test_single();
    do_reset();
    push_pair(32'h3F800000, 32'h40000000);
    wait_idle(100);
    checks++; if (res_z !== 32'h40400000) begin failures++; $display("FAIL single_res got=%h expected=40400000", res_z); end
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL single_txn got=%0d expected=1", txn_count); end
    checks++; if (signature !== 32'h40400000) begin failures++; $display("FAIL single_sig got=%h expected=40400000", signature); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b expected=0", busy); end
  endtask

  task automatic test_fill();
    int acc = 0;
    bit stable = 1'b1;
    do_reset();
    fpu_a_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_a = 32'h1000 + 32'(i);
      load_b = 32'h0010 + 32'(i);
      load_valid = 1'b1;
      if (load_ready) begin
        exp_q.push_back(fadd_ref(load_a, load_b));
        acc++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    checks++; if (acc != 4) begin failures++; $display("FAIL fill_accepted got=%0d expected=4", acc); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL fill_load_ready got=%b expected=0", load_ready); end
    for (int i = 0; i < 8; i++) begin
      if (fpu_a_stb !== 1'b1 || fpu_a !== 32'h1000) stable = 1'b0;
      @(negedge clk);
    end
    checks++; if (!stable) begin failures++; $display("FAIL fill_a_hold got=%b/%h expected=1/00001000", fpu_a_stb, fpu_a); end
    fpu_a_ack = 1'b1;
    wait_idle(300);
    checks++; if (txn_count !== 16'd4) begin failures++; $display("FAIL fill_txn got=%0d expected=4", txn_count); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    bit stable = 1'b1;
    bit seen = 1'b0;
    do_reset();
    res_ready = 1'b0;
    push_pair(32'h00000050, 32'h00000007);
    push_pair(32'h00000090, 32'h00000003);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (res_valid) seen = 1'b1; else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL bp_valid_timeout got=0 expected=1"); end
    held = res_z;
    for (int i = 0; i < 10; i++) begin
      if (res_z !== held || fpu_a_stb !== 1'b0 || res_valid !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    checks++; if (!stable) begin failures++; $display("FAIL bp_hold got=%h/%b expected=%h/0", res_z, fpu_a_stb, held); end
    checks++; if (held !== 32'h00000049) begin failures++; $display("FAIL bp_first_res got=%h expected=00000049", held); end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL bp_txn_step got=%0d expected=1", txn_count); end
    @(negedge clk);
    checks++; if (txn_count !== 16'd1 || fpu_a_stb !== 1'b1) begin failures++; $display("FAIL bp_next_start got=%0d/%b expected=1/1", txn_count, fpu_a_stb); end
    wait_idle(100);
    checks++; if (txn_count !== 16'd2) begin failures++; $display("FAIL bp_txn_final got=%0d expected=2", txn_count); end
  endtask

  task automatic test_special();
    do_reset();
    push_pair(32'h7F800000, 32'hFF800000);
    wait_idle(100);
    checks++; if (res_z !== 32'hFFC00000) begin failures++; $display("FAIL inf_res got=%h expected=ffc00000", res_z); end
    push_pair(32'h3F800000, 32'hBF800000);
    wait_idle(100);
    checks++; if (res_z !== 32'h00000000) begin failures++; $display("FAIL zero_res got=%h expected=00000000", res_z); end
    checks++; if (signature !== 32'hFF800001 || signature !== sig_m) begin failures++; $display("FAIL special_sig got=%h expected=ff800001", signature); end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    bit stale = 1'b0;
    do_reset();
    z_block = 1'b1;
    load_a = 32'h11; load_b = 32'h01; load_valid = 1'b1; @(negedge clk);
    load_a = 32'h22; load_b = 32'h02; @(negedge clk);
    load_a = 32'h33; load_b = 32'h03; @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (fpu_z_ack) seen = 1'b1; else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_wait_z got=0 expected=1"); end
    rst = 1'b1;
    z_block = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid} !== 4'b0) begin failures++; $display("FAIL mid_flags got=%b expected=0000", {fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid}); end
    checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_fifo got=%b/%b expected=1/0", load_ready, busy); end
    checks++; if (txn_count !== 16'd0 || signature !== '0) begin failures++; $display("FAIL mid_count_sig got=%0d/%h expected=0/0", txn_count, signature); end
    for (int i = 0; i < 20; i++) begin
      if (res_valid || fpu_a_stb) stale = 1'b1;
      @(negedge clk);
    end
    checks++; if (stale) begin failures++; $display("FAIL mid_stale got=activity expected=none"); end
  endtask

  task automatic test_wrap();
    logic [1:0] expw;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_pair(32'h500 + 32'(i), 32'h5);
      wait_idle(100);
      expw = 2'(i + 1);
      checks++; if (w2_txn !== expw) begin failures++; $display("FAIL wrap_txn_%0d got=%0d expected=%0d", i, w2_txn, expw); end
    end
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_a = '0;
    load_b = '0;
    fpu_a_ack = 1'b1;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_special();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
